// File: rtl/my_32bit1to16_write_bank_pkg.sv
// Shared constants and helpers for the 16-entry, 32-bit write bank.
// The write side mirrors the 16-to-1 read mux tree.
package my_32bit1to16_write_bank_pkg;

    localparam int NUM_ENTRIES    = 16;
    localparam int SEL_WIDTH      = 4;
    localparam int ENTRY_ZERO_IDX = 0;

    typedef logic [SEL_WIDTH-1:0]   sel_t;
    typedef logic [NUM_ENTRIES-1:0] mask_t;

    // Value the written-valid mask returns to on reset or clear.
    function automatic mask_t valid_base(input bit zero_entry0);
        mask_t m;
        m = '0;
        if (zero_entry0) begin
            m[ENTRY_ZERO_IDX] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/my_4to16_decoder.sv
// Select-to-one-hot write enable; the write-side image of the read mux tree.
// No line is high unless en is set.
module my_4to16_decoder
    import my_32bit1to16_write_bank_pkg::*;
(
    input  logic [SEL_WIDTH-1:0]   sel,
    input  logic                   en,
    output logic [NUM_ENTRIES-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/my_32bit1to16_write_bank.sv
// 16 x DATA_WIDTH write bank: one-cycle staged valid/ready write path,
// one-hot commit into the entry array, flattened bus for the read muxes.
module my_32bit1to16_write_bank
    import my_32bit1to16_write_bank_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter bit ZERO_ENTRY0 = 1'b1
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              write_valid,
    output logic                              write_ready,
    input  logic [SEL_WIDTH-1:0]              write_select,
    input  logic [DATA_WIDTH-1:0]             write_data,
    input  logic                              hold,
    input  logic                              clear_all,
    output logic [NUM_ENTRIES*DATA_WIDTH-1:0] output_bus,
    output logic [NUM_ENTRIES-1:0]            entry_valid,
    output logic                              commit_pulse,
    output logic [SEL_WIDTH-1:0]              commit_select
);

    localparam mask_t VALID_BASE = valid_base(ZERO_ENTRY0);

    logic                  transfer;
    logic                  pend_valid;
    sel_t                  pend_sel;
    logic [DATA_WIDTH-1:0] pend_data;
    mask_t                 wr_en;

    // Reset term keeps the handshake closed while the bank is in reset.
    assign write_ready   = reset & ~hold & ~clear_all;
    assign transfer      = write_valid & write_ready;
    assign commit_pulse  = pend_valid & ~hold & ~clear_all;
    assign commit_select = pend_sel;

    // Stage 1: staging register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_valid <= 1'b0;
            pend_sel   <= '0;
            pend_data  <= '0;
        end else if (clear_all) begin
            pend_valid <= 1'b0;
        end else if (!hold) begin
            pend_valid <= transfer;
            if (transfer) begin
                pend_sel  <= write_select;
                pend_data <= write_data;
            end
        end
    end

    // Stage 2: commit decode and entry array
    my_4to16_decoder u_decoder (
        .sel    (pend_sel),
        .en     (commit_pulse),
        .onehot (wr_en)
    );

    for (genvar k = 0; k < NUM_ENTRIES; k++) begin : g_entry
        // The hardwired entry still sees its enable but always loads zero.
        localparam bit IS_ZERO = ZERO_ENTRY0 && (k == ENTRY_ZERO_IDX);

        logic [DATA_WIDTH-1:0] entry_q;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                entry_q <= '0;
            end else if (clear_all) begin
                entry_q <= '0;
            end else if (wr_en[k]) begin
                entry_q <= IS_ZERO ? '0 : pend_data;
            end
        end

        assign output_bus[DATA_WIDTH*k +: DATA_WIDTH] = entry_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            entry_valid <= VALID_BASE;
        end else if (clear_all) begin
            entry_valid <= VALID_BASE;
        end else begin
            entry_valid <= entry_valid | wr_en | VALID_BASE;
        end
    end

endmodule

// File: tb/tb_my_32bit1to16_write_bank.sv
// Scoreboard bench for my_32bit1to16_write_bank: directed scenarios then
// randomized traffic against a memory-array reference model.
module tb_my_32bit1to16_write_bank;

    localparam bit          ZERO = 1'b1;
    localparam logic [15:0] BASE = ZERO ? 16'h0001 : 16'h0000;

    typedef struct packed {
        logic [3:0]  sel;
        logic [31:0] data;
    } wr_t;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         write_valid = 1'b0;
    logic         write_ready;
    logic [3:0]   write_select = 4'd0;
    logic [31:0]  write_data = 32'd0;
    logic         hold = 1'b0;
    logic         clear_all = 1'b0;
    logic [511:0] output_bus;
    logic [15:0]  entry_valid;
    logic         commit_pulse;
    logic [3:0]   commit_select;

    int checks = 0;
    int errors = 0;
    int commit_count = 0;

    logic [31:0] mem [16];
    logic [15:0] mval;
    wr_t         exp_q[$];
    wr_t         commit_q[$];

    my_32bit1to16_write_bank #(
        .DATA_WIDTH  (32),
        .ZERO_ENTRY0 (ZERO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .write_valid   (write_valid),
        .write_ready   (write_ready),
        .write_select  (write_select),
        .write_data    (write_data),
        .hold          (hold),
        .clear_all     (clear_all),
        .output_bus    (output_bus),
        .entry_valid   (entry_valid),
        .commit_pulse  (commit_pulse),
        .commit_select (commit_select)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then step past the next rising edge.
    task automatic cyc(input logic v, input logic [3:0] s, input logic [31:0] d,
                       input logic h, input logic c);
        write_valid  = v;
        write_select = s;
        write_data   = d;
        hold         = h;
        clear_all    = c;
        @(posedge clock);
        #1;
    endtask

    // Reference model: accepted writes enter exp_q; commits seen by the
    // monitor land in the memory array at the following edge.
    always @(posedge clock or negedge reset) begin
        wr_t it;
        if (!reset) begin
            for (int k = 0; k < 16; k++) mem[k] = 32'd0;
            mval = BASE;
            exp_q.delete();
            commit_q.delete();
        end else begin
            if (commit_q.size() != 0) begin
                it = commit_q.pop_front();
                if (!(ZERO && it.sel == 4'd0)) mem[it.sel] = it.data;
                mval[it.sel] = 1'b1;
            end
            if (clear_all) begin
                for (int k = 0; k < 16; k++) mem[k] = 32'd0;
                mval = BASE;
                exp_q.delete();
            end else if (!hold && write_valid) begin
                exp_q.push_back('{sel: write_select, data: write_data});
            end
        end
    end

    // Monitor: compares every cycle on the falling edge.
    always @(negedge clock) begin
        logic [511:0] eb;
        logic         exp_commit;
        wr_t          it;
        for (int k = 0; k < 16; k++) eb[32*k +: 32] = mem[k];
        chk("bus", output_bus, eb);
        chk("valid_mask", {496'd0, entry_valid}, {496'd0, mval});
        chk("ready", {511'd0, write_ready}, {511'd0, reset & ~hold & ~clear_all});
        exp_commit = reset && !hold && !clear_all && (exp_q.size() != 0);
        chk("commit_pulse", {511'd0, commit_pulse}, {511'd0, exp_commit});
        if (commit_pulse && exp_q.size() != 0) begin
            it = exp_q.pop_front();
            chk("commit_select", {508'd0, commit_select}, {508'd0, it.sel});
            commit_q.push_back(it);
            commit_count++;
        end
    end

    initial begin
        int c0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_bus", output_bus, 512'd0);
        chk("rst_valid", {496'd0, entry_valid}, {496'd0, BASE});
        chk("rst_ready", {511'd0, write_ready}, 512'd0);
        chk("rst_commit", {511'd0, commit_pulse}, 512'd0);
        reset = 1'b1;
        #1;
        chk("ready_after_rst", {511'd0, write_ready}, 512'd1);

        // single write, latency
        cyc(1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 1'b0);
        chk("t1_commit", {511'd0, commit_pulse}, 512'd1);
        chk("t1_csel", {508'd0, commit_select}, 512'd5);
        cyc(1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        chk("t1_entry5", {480'd0, output_bus[191:160]}, {480'd0, 32'hDEADBEEF});
        chk("t1_valid", {496'd0, entry_valid}, {496'd0, 16'h0021});

        // clear, then back-to-back writes
        cyc(1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        chk("clr_bus", output_bus, 512'd0);
        chk("clr_valid", {496'd0, entry_valid}, 512'd1);
        c0 = commit_count;
        cyc(1'b1, 4'd3, 32'h11111111, 1'b0, 1'b0);
        cyc(1'b1, 4'd3, 32'h22222222, 1'b0, 1'b0);
        cyc(1'b1, 4'd15, 32'hFFFF0000, 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        chk("b2b_entry3", {480'd0, output_bus[127:96]}, {480'd0, 32'h22222222});
        chk("b2b_entry15", {480'd0, output_bus[511:480]}, {480'd0, 32'hFFFF0000});
        chk("b2b_valid", {496'd0, entry_valid}, {496'd0, 16'h8009});
        chk("b2b_commits", 512'(commit_count - c0), 512'd3);

        // write to hardwired entry 0
        c0 = commit_count;
        cyc(1'b1, 4'd0, 32'h12345678, 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        chk("z_entry0", {480'd0, output_bus[31:0]}, 512'd0);
        chk("z_valid0", {511'd0, entry_valid[0]}, 512'd1);
        chk("z_commits", 512'(commit_count - c0), 512'd1);

        // hold freezes a staged write
        cyc(1'b1, 4'd7, 32'hA5A5A5A5, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
            chk("h_ready", {511'd0, write_ready}, 512'd0);
            chk("h_commit", {511'd0, commit_pulse}, 512'd0);
        end
        chk("h_entry7_frozen", {480'd0, output_bus[255:224]}, 512'd0);
        cyc(1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        chk("h_entry7", {480'd0, output_bus[255:224]}, {480'd0, 32'hA5A5A5A5});

        // clear_all on the commit cycle
        cyc(1'b1, 4'd9, 32'h0BADF00D, 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        chk("cc_bus", output_bus, 512'd0);
        chk("cc_valid", {496'd0, entry_valid}, 512'd1);
        cyc(1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        chk("cc_entry9", {480'd0, output_bus[319:288]}, 512'd0);

        // asynchronous reset with a write staged
        cyc(1'b1, 4'd4, 32'hCAFEF00D, 1'b0, 1'b0);
        cyc(1'b1, 4'd2, 32'h13572468, 1'b0, 1'b0);
        chk("ar_entry4_pre", {480'd0, output_bus[159:128]}, {480'd0, 32'hCAFEF00D});
        #1 reset = 1'b0;
        #1;
        chk("ar_bus", output_bus, 512'd0);
        chk("ar_valid", {496'd0, entry_valid}, 512'd1);
        chk("ar_ready", {511'd0, write_ready}, 512'd0);
        chk("ar_commit", {511'd0, commit_pulse}, 512'd0);
        write_valid = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        #1;
        chk("ar_ready_rel", {511'd0, write_ready}, 512'd1);
        cyc(1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        chk("ar_entry2", {480'd0, output_bus[95:64]}, 512'd0);
        chk("ar_valid_post", {496'd0, entry_valid}, 512'd1);

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            cyc($urandom_range(0, 3) != 0, 4'($urandom), $urandom,
                $urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0);
        end
        repeat (3) cyc(1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        chk("drain", 512'(exp_q.size()), 512'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
